// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared sizes, states and address check for the dmem access controller
package dmem_access_pkg;

   // Access size encoding on req_size; 2'b11 is never a legal access
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Byte address that lands on dmem word 0
   localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_MERGE  = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Reject a request before it touches memory: bad size, misaligned, or past the window.
   // off is the wrapped byte offset from the window base, so addresses below the base
   // become huge offsets and fail the window test as well.
   function automatic logic access_err(input logic [1:0] size,
                                       input logic [31:0] off,
                                       input int unsigned depth);
      logic [31:0] lim;
      logic        bad;
      lim = {depth[29:0], 2'b00};
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad | (off >= lim);
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_merge_extract.sv
// rtl/dmem_access_ctrl_lane_merge_extract.sv - little-endian lane extract/extend for loads and lane insert for stores
module lane_merge_extract
   import dmem_access_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_rword,
   input  logic [31:0] i_old,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte and halfword out of the read word
   always_comb begin
      w_byte = i_rword[7:0];
      case (i_lane)
         2'd0:    w_byte = i_rword[7:0];
         2'd1:    w_byte = i_rword[15:8];
         2'd2:    w_byte = i_rword[23:16];
         default: w_byte = i_rword[31:24];
      endcase
      w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
   end

   // Sign- or zero-extend the selected lane into a full load result
   always_comb begin
      o_load = i_rword;
      case (i_size)
         SZ_BYTE: o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
         default: o_load = i_rword;
      endcase
   end

   // Replace only the addressed lane of the old word with the right-justified store data
   always_comb begin
      o_merge = i_old;
      case (i_size)
         SZ_BYTE: begin
            case (i_lane)
               2'd0:    o_merge[7:0]   = i_wdata[7:0];
               2'd1:    o_merge[15:8]  = i_wdata[7:0];
               2'd2:    o_merge[23:16] = i_wdata[7:0];
               default: o_merge[31:24] = i_wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
            else           o_merge[15:0]  = i_wdata[15:0];
         end
         default: o_merge = i_wdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - single-outstanding load/store initiator for the word-wide dmem port
module dmem_access_ctrl
   import dmem_access_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEFAULT,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned AW        = 11
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   output logic          resp_err,
   output logic [31:0]   resp_rdata,
   output logic          dmem_ena,
   output logic          dmem_write,
   output logic          dmem_read,
   output logic [AW-1:0] dmem_addr,
   output logic [31:0]   dmem_wdata,
   input  logic [31:0]   dmem_rdata
);

   state_t        r_state;
   state_t        w_next;

   logic          r_we;
   logic [1:0]    r_size;
   logic          r_unsigned;
   logic [AW-1:0] r_index;
   logic [1:0]    r_lane;
   logic [31:0]   r_wdata;
   logic          r_err;
   logic [31:0]   r_old;
   logic [31:0]   r_rdata;

   logic [31:0]   w_off;
   logic          w_err;
   logic [31:0]   w_load;
   logic [31:0]   w_merge;

   assign w_off      = req_addr - DMEM_BASE;
   assign w_err      = access_err(req_size, w_off, DEPTH);
   assign resp_rdata = r_rdata;

   lane_merge_extract u_lane (
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_lane     (r_lane),
      .i_rword    (dmem_rdata),
      .i_old      (r_old),
      .i_wdata    (r_wdata),
      .o_load     (w_load),
      .o_merge    (w_merge)
   );

   // State register; reset drops any in-flight access back to idle
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next state and all dmem/response strobes decoded from the current state
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      dmem_ena   = 1'b0;
      dmem_write = 1'b0;
      dmem_read  = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = w_err ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            dmem_ena  = 1'b1;
            dmem_addr = r_index;
            if (r_we && (r_size == SZ_WORD)) begin
               dmem_write = 1'b1;
               dmem_wdata = r_wdata;
               w_next     = ST_RESP;
            end else if (r_we) begin
               dmem_read = 1'b1;
               w_next    = ST_MERGE;
            end else begin
               dmem_read = 1'b1;
               w_next    = ST_RESP;
            end
         end
         ST_MERGE: begin
            dmem_ena   = 1'b1;
            dmem_write = 1'b1;
            dmem_addr  = r_index;
            dmem_wdata = w_merge;
            w_next     = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_err   = r_err;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Request latch, read capture and result register; resp_rdata only changes on the way into RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we       <= 1'b0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_index    <= '0;
         r_lane     <= 2'b00;
         r_wdata    <= '0;
         r_err      <= 1'b0;
         r_old      <= '0;
         r_rdata    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_index    <= w_off[AW+1:2];
                  r_lane     <= w_off[1:0];
                  r_wdata    <= req_wdata;
                  r_err      <= w_err;
                  if (w_err) r_rdata <= '0;
               end
            end
            ST_ACCESS: begin
               if (!r_we)                  r_rdata <= w_load;
               else if (r_size == SZ_WORD) r_rdata <= '0;
               else                        r_old   <= dmem_rdata;
            end
            ST_MERGE: r_rdata <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed vector bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

   localparam logic [31:0] BASE = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        dmem_ena, dmem_write, dmem_read;
   logic [10:0] dmem_addr;
   logic [31:0] dmem_wdata, dmem_rdata;

   logic [31:0] mem [0:1023];

   int n_checks = 0;
   int n_errors = 0;
   int n_strobe = 0;
   int n_write  = 0;
   int n_resp   = 0;
   logic [10:0] last_addr = '0;

   always #5 clk = ~clk;

   dmem_access_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .dmem_ena(dmem_ena), .dmem_write(dmem_write), .dmem_read(dmem_read),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
   );

   // Memory model: garbage when not reading, so an unqualified sample shows up
   assign dmem_rdata = dmem_read ? mem[dmem_addr] : 32'hDEAD_0BAD;

   always @(posedge clk) begin
      if (dmem_ena && dmem_write) mem[dmem_addr] <= dmem_wdata;
      if (dmem_ena || dmem_write || dmem_read) n_strobe <= n_strobe + 1;
      if (dmem_write) n_write <= n_write + 1;
      if (dmem_ena) last_addr <= dmem_addr;
      if (resp_valid) n_resp <= n_resp + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          strobes;
      int          writes;
      int          idx;
      logic [31:0] word;
   } vec_t;

   // Called at a negedge with the DUT idle; returns at the negedge after RESP
   task automatic do_req(input vec_t v);
      int s0, w0, lat;
      s0 = n_strobe;
      w0 = n_write;
      chk({v.name, ".ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk);
      #1;
      // Busy-time junk: a word store to word 4 that must never be taken
      req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = BASE + 32'h10; req_wdata = 32'hBAD0_BAD0;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (resp_valid) break;
         req_valid = ~req_valid;
      end
      req_valid = 1'b0;
      chk({v.name, ".latency"}, lat, v.lat);
      chk({v.name, ".err"}, {31'd0, resp_err}, {31'd0, v.err});
      chk({v.name, ".rdata"}, resp_rdata, v.rdata);
      @(negedge clk);
      chk({v.name, ".pulse"}, {31'd0, resp_valid}, 32'd0);
      chk({v.name, ".strobes"}, n_strobe - s0, v.strobes);
      chk({v.name, ".writes"}, n_write - w0, v.writes);
      if (v.idx >= 0) begin
         chk({v.name, ".addr"}, {21'd0, last_addr}, v.idx);
         if (v.we) chk({v.name, ".mem"}, mem[v.idx], v.word);
      end
   endtask

   vec_t vecs [$];

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      //          name      we  size   uns  addr            wdata          err  rdata          lat st wr idx word
      vecs.push_back('{"sw",   1, 2'b10, 0, 32'h1001_0008, 32'hDEADBEEF, 0, 32'h0,        2, 1, 1, 2, 32'hDEADBEEF});
      vecs.push_back('{"lb",   0, 2'b00, 0, 32'h1001_000B, 32'h0,        0, 32'hFFFFFFDE, 2, 1, 0, 2, 32'h0});
      vecs.push_back('{"lbu",  0, 2'b00, 1, 32'h1001_000B, 32'h0,        0, 32'h000000DE, 2, 1, 0, 2, 32'h0});
      vecs.push_back('{"lh",   0, 2'b01, 0, 32'h1001_0008, 32'h0,        0, 32'hFFFFBEEF, 2, 1, 0, 2, 32'h0});
      vecs.push_back('{"lhu",  0, 2'b01, 1, 32'h1001_0008, 32'h0,        0, 32'h0000BEEF, 2, 1, 0, 2, 32'h0});
      vecs.push_back('{"sb",   1, 2'b00, 0, 32'h1001_000A, 32'h12345677, 0, 32'h0,        3, 2, 1, 2, 32'hDE77BEEF});
      vecs.push_back('{"sh",   1, 2'b01, 0, 32'h1001_0008, 32'hAAAA1234, 0, 32'h0,        3, 2, 1, 2, 32'hDE771234});
      vecs.push_back('{"lw",   0, 2'b10, 0, 32'h1001_0008, 32'h0,        0, 32'hDE771234, 2, 1, 0, 2, 32'h0});
      vecs.push_back('{"lw_mis",0,2'b10, 0, 32'h1001_0006, 32'h0,        1, 32'h0,        1, 0, 0, -1, 32'h0});
      vecs.push_back('{"sh_mis",1,2'b01, 0, 32'h1001_0003, 32'h5555,     1, 32'h0,        1, 0, 0, -1, 32'h0});
      vecs.push_back('{"lh_hi",0, 2'b01, 0, 32'h1001_000A, 32'h0,        0, 32'hFFFFDE77, 2, 1, 0, 2, 32'h0});
      vecs.push_back('{"lw_oow",0,2'b10, 0, 32'h1001_1000, 32'h0,        1, 32'h0,        1, 0, 0, -1, 32'h0});
      vecs.push_back('{"lhu_hi",0,2'b01, 1, 32'h1001_000A, 32'h0,        0, 32'h0000DE77, 2, 1, 0, 2, 32'h0});
      vecs.push_back('{"sz11", 0, 2'b11, 0, 32'h1001_0008, 32'h0,        1, 32'h0,        1, 0, 0, -1, 32'h0});
      vecs.push_back('{"lb_pos",0,2'b00, 0, 32'h1001_0009, 32'h0,        0, 32'h00000012, 2, 1, 0, 2, 32'h0});
      vecs.push_back('{"lw_low",0,2'b10, 0, 32'h1000_FFFC, 32'h0,        1, 32'h0,        1, 0, 0, -1, 32'h0});
      vecs.push_back('{"sb_top",1,2'b00, 0, 32'h1001_0FFF, 32'h00000080, 0, 32'h0,        3, 2, 1, 1023, 32'h80000000});
      vecs.push_back('{"lb_top",0,2'b00, 0, 32'h1001_0FFF, 32'h0,        0, 32'hFFFFFF80, 2, 1, 0, 1023, 32'h0});

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst.ready", {31'd0, req_ready}, 32'd1);
      chk("rst.resp", {30'd0, resp_valid, resp_err}, 32'd0);
      chk("rst.rdata", resp_rdata, 32'd0);
      chk("rst.strobes", {29'd0, dmem_ena, dmem_write, dmem_read}, 32'd0);
      chk("rst.addr", {21'd0, dmem_addr}, 32'd0);
      chk("rst.wdata", dmem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) do_req(vecs[i]);

      // Reset during the read half of a byte store: nothing may be written or answered
      begin
         int w0, r0;
         w0 = n_write;
         r0 = n_resp;
         req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
         req_addr = 32'h1001_0008; req_wdata = 32'h0000_0055;
         @(posedge clk);
         #1 req_valid = 1'b0;
         @(negedge clk);
         chk("abort.access_read", {30'd0, dmem_read, dmem_write}, 32'd2);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("abort.ready", {31'd0, req_ready}, 32'd1);
         repeat (4) @(negedge clk);
         chk("abort.writes", n_write - w0, 0);
         chk("abort.resp", n_resp - r0, 0);
         chk("abort.mem", mem[2], 32'hDE771234);
      end

      chk("junk.mem4", mem[4], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
